// File: rtl/dmac_engine_mo.sv
// Single-channel AXI DMA copy engine: reads bursts into a FIFO, writes them back out, and tracks outstanding B responses.
// Optional DMAC_RESP_ERR_EN makes err_o a sticky flag for non-OKAY R/B responses; without it err_o is tied low.
module dmac_engine_mo #(
   parameter int DATA_W          = 32,
   parameter int MAX_BURST       = 16,
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         src_addr_i,
   input  logic [31:0]         dst_addr_i,
   input  logic [15:0]         byte_len_i,
   input  logic                start_i,
   output logic                done_o,
   output logic                err_o,
   output logic [31:0]         araddr_o,
   output logic [3:0]          arlen_o,
   output logic [2:0]          arsize_o,
   output logic [1:0]          arburst_o,
   output logic                arvalid_o,
   input  logic                arready_i,
   input  logic [DATA_W-1:0]   rdata_i,
   input  logic [1:0]          rresp_i,
   input  logic                rlast_i,
   input  logic                rvalid_i,
   output logic                rready_o,
   output logic [31:0]         awaddr_o,
   output logic [3:0]          awlen_o,
   output logic [2:0]          awsize_o,
   output logic [1:0]          awburst_o,
   output logic                awvalid_o,
   input  logic                awready_i,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   output logic                wlast_o,
   output logic                wvalid_o,
   input  logic                wready_i,
   input  logic [1:0]          bresp_i,
   input  logic                bvalid_i,
   output logic                bready_o
);

   localparam int          BB        = DATA_W / 8;
   localparam int          BSHIFT    = $clog2(BB);
   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [15:0] MAX_BYTES = 16'(MAX_BURST * BB);
   localparam logic [15:0] LOW_MASK  = 16'(BB - 1);

   typedef enum logic [2:0] {IDLE, RREQ, RDATA, WREQ, WDATA, WAIT} state_t;

   state_t              state, state_nxt;
   logic [31:0]         src_addr, dst_addr;
   logic [15:0]         rem, cur;
   logic [3:0]          burst_len, wcnt, out_cnt;
   logic [PTR_W:0]      wr_ptr, rd_ptr, fifo_cnt;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic                fifo_full, fifo_empty, start_ok;
   logic                ar_hs, r_hs, aw_hs, w_hs, b_dec;

   assign cur        = (rem > MAX_BYTES) ? MAX_BYTES : rem;
   assign burst_len  = 4'((cur >> BSHIFT) - 16'd1);
   assign fifo_cnt   = wr_ptr - rd_ptr;
   assign fifo_full  = fifo_cnt[PTR_W];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign start_ok   = (state == IDLE) && start_i && ((byte_len_i & ~LOW_MASK) != 16'd0);

   assign araddr_o  = src_addr;
   assign arlen_o   = burst_len;
   assign arsize_o  = 3'(BSHIFT);
   assign arburst_o = 2'b01;
   assign awaddr_o  = dst_addr;
   assign awlen_o   = burst_len;
   assign awsize_o  = 3'(BSHIFT);
   assign awburst_o = 2'b01;
   assign wstrb_o   = '1;
   assign wdata_o   = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign bready_o  = 1'b1;

   assign ar_hs = arvalid_o && arready_i;
   assign r_hs  = rready_o && rvalid_i;
   assign aw_hs = awvalid_o && awready_i;
   assign w_hs  = wvalid_o && wready_i;
   assign b_dec = bvalid_i && (out_cnt != 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arvalid_o = 1'b0;
      rready_o  = 1'b0;
      awvalid_o = 1'b0;
      wvalid_o  = 1'b0;
      wlast_o   = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            done_o = 1'b1;
            if (start_ok) state_nxt = RREQ;
         end
         RREQ: begin
            arvalid_o = 1'b1;
            if (arready_i) state_nxt = RDATA;
         end
         RDATA: begin
            rready_o = !fifo_full;
            if (rvalid_i && !fifo_full && rlast_i) state_nxt = WREQ;
         end
         WREQ: begin
            awvalid_o = (out_cnt < 4'(MAX_OUTSTANDING));
            if ((out_cnt < 4'(MAX_OUTSTANDING)) && awready_i) state_nxt = WDATA;
         end
         WDATA: begin
            wvalid_o = !fifo_empty;
            wlast_o  = (wcnt == 4'd0);
            if (!fifo_empty && wready_i && (wcnt == 4'd0))
               state_nxt = (rem == 16'd0) ? WAIT : RREQ;
         end
         WAIT: begin
            if (out_cnt == 4'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // rem shrinks when the write burst is committed, so cur stays valid across the R and W phases
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_addr <= '0;
         dst_addr <= '0;
         rem      <= '0;
         wcnt     <= '0;
      end else begin
         if (start_ok) begin
            src_addr <= src_addr_i;
            dst_addr <= dst_addr_i;
            rem      <= byte_len_i & ~LOW_MASK;
         end
         if (ar_hs) src_addr <= src_addr + {16'd0, cur};
         if (aw_hs) begin
            dst_addr <= dst_addr + {16'd0, cur};
            wcnt     <= burst_len;
            rem      <= rem - cur;
         end else if (w_hs) begin
            wcnt <= wcnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 out_cnt <= '0;
      else if (aw_hs && !b_dec) out_cnt <= out_cnt + 4'd1;
      else if (!aw_hs && b_dec) out_cnt <= out_cnt - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (r_hs) wr_ptr <= wr_ptr + 1'b1;
         if (w_hs) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r_hs) fifo_mem[wr_ptr[PTR_W-1:0]] <= rdata_i;
   end

`ifdef DMAC_RESP_ERR_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           err_q <= 1'b0;
      else if (start_ok) err_q <= 1'b0;
      else if ((r_hs && (rresp_i != 2'b00)) || (bvalid_i && (bresp_i != 2'b00)))
         err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   logic resp_unused;
   assign resp_unused = ^{rresp_i, bresp_i};
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_engine_mo.sv
// Directed bench for dmac_engine_mo: an AXI slave model with source pattern and destination memory.
module tb_dmac_engine_mo;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src_addr_i, dst_addr_i;
   logic [15:0] byte_len_i;
   logic        start_i, done_o, err_o;
   logic [31:0] araddr_o, awaddr_o;
   logic [3:0]  arlen_o, awlen_o;
   logic [2:0]  arsize_o, awsize_o;
   logic [1:0]  arburst_o, awburst_o;
   logic        arvalid_o, arready_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rlast_i, rvalid_i, rready_o;
   logic        awvalid_o, awready_i;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb_o;
   logic        wlast_o, wvalid_o, wready_i;
   logic [1:0]  bresp_i;
   logic        bvalid_i, bready_o;

   always #5 clk = ~clk;

   dmac_engine_mo #(.DATA_W(32), .MAX_BURST(16), .FIFO_DEPTH(16), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst(rst), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
      .byte_len_i(byte_len_i), .start_i(start_i), .done_o(done_o), .err_o(err_o),
      .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
      .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  len;
   } burst_t;

   int          total_cnt = 0;
   int          bad_cnt   = 0;
   burst_t      ar_q[$];
   burst_t      aw_q[$];
   int          r_beat, w_beat, r_stall, w_stall, b_pending;
   int          ar_cnt, aw_cnt, w_cnt, b_cnt, cur_out, max_out;
   int          b_err_idx;
   logic        stall_en, b_en;
   logic [3:0]  first_arlen;
   logic [31:0] aw_addr_log [16];
   logic [3:0]  aw_len_log [16];
   logic [31:0] dst_mem [logic [31:0]];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] srcWord(input logic [31:0] a);
      return 32'hC0DE0000 + (a >> 2);
   endfunction

   // Slave model: drives inputs at each falling edge, then books the handshakes the next rising edge will take
   initial begin
      burst_t nb;
      arready_i = 1'b1; awready_i = 1'b1; wready_i = 1'b1;
      rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0;
      bvalid_i = 1'b0; bresp_i = 2'b00;
      r_beat = 0; w_beat = 0; r_stall = 0; w_stall = 0; b_pending = 0; cur_out = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ar_q.delete(); aw_q.delete();
            r_beat = 0; w_beat = 0; r_stall = 0; w_stall = 0; b_pending = 0; cur_out = 0;
            rvalid_i = 1'b0; rlast_i = 1'b0; bvalid_i = 1'b0; wready_i = 1'b1;
         end else begin
            if (r_stall > 0) begin
               r_stall--; rvalid_i = 1'b0; rlast_i = 1'b0;
            end else if (ar_q.size() > 0) begin
               rvalid_i = 1'b1;
               rdata_i  = srcWord(ar_q[0].addr + 32'(r_beat * 4));
               rlast_i  = (r_beat == int'(ar_q[0].len));
            end else begin
               rvalid_i = 1'b0; rlast_i = 1'b0;
            end
            if (w_stall > 0) begin
               w_stall--; wready_i = 1'b0;
            end else wready_i = 1'b1;
            if (b_en && b_pending > 0) begin
               bvalid_i = 1'b1;
               bresp_i  = (b_cnt == b_err_idx) ? 2'b10 : 2'b00;
            end else begin
               bvalid_i = 1'b0; bresp_i = 2'b00;
            end
            #1;
            if (arvalid_o && arready_i) begin
               if (ar_cnt == 0) first_arlen = arlen_o;
               nb.addr = araddr_o; nb.len = arlen_o;
               ar_q.push_back(nb);
               ar_cnt++;
            end
            if (rvalid_i && rready_o) begin
               r_beat++;
               if (r_beat > int'(ar_q[0].len)) begin
                  void'(ar_q.pop_front());
                  r_beat = 0;
               end
               if (stall_en) r_stall = $urandom_range(0, 5);
            end
            if (awvalid_o && awready_i) begin
               if (aw_cnt < 16) begin
                  aw_addr_log[aw_cnt] = awaddr_o;
                  aw_len_log[aw_cnt]  = awlen_o;
               end
               nb.addr = awaddr_o; nb.len = awlen_o;
               aw_q.push_back(nb);
               aw_cnt++; cur_out++;
               if (cur_out > max_out) max_out = cur_out;
            end
            if (wvalid_o && wready_i) begin
               if (aw_q.size() == 0) checkOutput("w_without_aw", 1, 0);
               else begin
                  dst_mem[aw_q[0].addr + 32'(w_beat * 4)] = wdata_o;
                  checkOutput("wlast_pos", wlast_o, (w_beat == int'(aw_q[0].len)));
                  w_cnt++;
                  if (w_beat == int'(aw_q[0].len)) begin
                     void'(aw_q.pop_front());
                     w_beat = 0;
                     b_pending++;
                  end else w_beat++;
               end
               if (stall_en) w_stall = $urandom_range(0, 5);
            end
            if (bvalid_i && bready_o) begin
               b_pending--; b_cnt++; cur_out--;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; max_out = 0;
      dst_mem.delete();
      src_addr_i = s; dst_addr_i = d; byte_len_i = len;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (done_o !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, done_o, 1);
   endtask

   task automatic checkMem(input string tag, input logic [31:0] s, input logic [31:0] d, input int words);
      int bad = 0;
      for (int i = 0; i < words; i++) begin
         logic [31:0] a;
         a = d + 32'(i * 4);
         if (!dst_mem.exists(a)) bad++;
         else if (dst_mem[a] !== srcWord(s + 32'(i * 4))) bad++;
      end
      checkOutput(tag, bad, 0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired before test end");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; byte_len_i = '0;
      stall_en = 1'b0; b_en = 1'b1; b_err_idx = -1;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; max_out = 0; first_arlen = '0;
      repeat (3) tick();
      checkOutput("rst_done", done_o, 1);
      checkOutput("rst_err", err_o, 0);
      checkOutput("rst_arvalid", arvalid_o, 0);
      checkOutput("rst_awvalid", awvalid_o, 0);
      checkOutput("rst_wvalid", wvalid_o, 0);
      checkOutput("rst_rready", rready_o, 0);
      checkOutput("rst_bready", bready_o, 1);
      rst = 1'b0;
      tick();

      $display("[TB] short length start is ignored");
      applyStimulus(32'h100, 32'h200, 16'd3);
      repeat (3) tick();
      checkOutput("short_done", done_o, 1);
      checkOutput("short_ar_cnt", ar_cnt, 0);

      $display("[TB] T1: 256 bytes, four full bursts");
      applyStimulus(32'h1000, 32'h8000, 16'd256);
      checkOutput("t1_ar_latency", arvalid_o, 1);
      checkOutput("t1_done_low", done_o, 0);
      checkOutput("t1_arsize", arsize_o, 2);
      checkOutput("t1_arburst", arburst_o, 1);
      checkOutput("t1_awsize", awsize_o, 2);
      checkOutput("t1_awburst", awburst_o, 1);
      checkOutput("t1_wstrb", wstrb_o, 4'hF);
      src_addr_i = 32'h7000; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0;
      while (b_cnt < 4 && n < 3000) begin
         tick();
         n++;
      end
      checkOutput("t1_b_cnt", b_cnt, 4);
      checkOutput("t1_done_at_last_b", done_o, 0);
      tick();
      checkOutput("t1_done_after_b_edge", done_o, 0);
      tick();
      checkOutput("t1_done_rise", done_o, 1);
      checkOutput("t1_ar_cnt", ar_cnt, 4);
      checkOutput("t1_aw_cnt", aw_cnt, 4);
      checkOutput("t1_arlen", first_arlen, 15);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t1_awaddr", aw_addr_log[i], 32'h8000 + 32'(i * 64));
         checkOutput("t1_awlen", aw_len_log[i], 15);
      end
      checkOutput("t1_w_cnt", w_cnt, 64);
      checkMem("t1_mem", 32'h1000, 32'h8000, 64);
      checkOutput("t1_err", err_o, 0);

      $display("[TB] T2: 23 bytes -> one 5-beat burst");
      applyStimulus(32'h2000, 32'h9000, 16'd23);
      waitDone("t2_done", 500);
      checkOutput("t2_ar_cnt", ar_cnt, 1);
      checkOutput("t2_arlen", first_arlen, 4);
      checkOutput("t2_awlen", aw_len_log[0], 4);
      checkOutput("t2_aw_cnt", aw_cnt, 1);
      checkOutput("t2_w_cnt", w_cnt, 5);
      checkMem("t2_mem", 32'h2000, 32'h9000, 5);
      checkOutput("t2_no_extra", dst_mem.exists(32'h9014), 0);

      $display("[TB] T3: B held off, outstanding limit of 2");
      b_en = 1'b0;
      applyStimulus(32'h3000, 32'hA000, 16'd256);
      n = 0;
      while (aw_cnt < 2 && n < 2000) begin
         tick();
         n++;
      end
      repeat (80) tick();
      checkOutput("t3_aw_cnt_stalled", aw_cnt, 2);
      checkOutput("t3_awvalid_low", awvalid_o, 0);
      checkOutput("t3_ar_cnt_stalled", ar_cnt, 3);
      checkOutput("t3_max_out", max_out, 2);
      checkOutput("t3_not_done", done_o, 0);
      b_en = 1'b1;
      waitDone("t3_done", 3000);
      checkOutput("t3_aw_cnt", aw_cnt, 4);
      checkOutput("t3_b_cnt", b_cnt, 4);
      checkMem("t3_mem", 32'h3000, 32'hA000, 64);

      $display("[TB] T4: 1 KB with random R/W stalls");
      stall_en = 1'b1;
      applyStimulus(32'h4000, 32'hB000, 16'd1024);
      waitDone("t4_done", 20000);
      stall_en = 1'b0;
      checkOutput("t4_ar_cnt", ar_cnt, 16);
      checkOutput("t4_aw_cnt", aw_cnt, 16);
      checkOutput("t4_max_out_ok", (max_out <= 2), 1);
      checkMem("t4_mem", 32'h4000, 32'hB000, 256);

      $display("[TB] T5: error response on second B");
      b_err_idx = 1;
      applyStimulus(32'h5000, 32'hC000, 16'd256);
      waitDone("t5_done", 3000);
      b_err_idx = -1;
`ifdef DMAC_RESP_ERR_EN
      checkOutput("t5_err_set", err_o, 1);
`else
      checkOutput("t5_err_tied", err_o, 0);
`endif
      checkOutput("t5_aw_cnt", aw_cnt, 4);
      checkOutput("t5_b_cnt", b_cnt, 4);
      checkMem("t5_mem", 32'h5000, 32'hC000, 64);
      applyStimulus(32'h5400, 32'hC400, 16'd8);
      checkOutput("t5_err_cleared", err_o, 0);
      waitDone("t5b_done", 500);
      checkMem("t5b_mem", 32'h5400, 32'hC400, 2);

      $display("[TB] T6: reset during write data");
      applyStimulus(32'h6000, 32'hD000, 16'd256);
      n = 0;
      while (wvalid_o !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      checkOutput("t6_in_wdata", wvalid_o, 1);
      rst = 1'b1;
      #1;
      checkOutput("t6_async_wvalid", wvalid_o, 0);
      checkOutput("t6_async_awvalid", awvalid_o, 0);
      checkOutput("t6_async_arvalid", arvalid_o, 0);
      checkOutput("t6_async_done", done_o, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("t6_post_done", done_o, 1);
      checkOutput("t6_post_rready", rready_o, 0);
      applyStimulus(32'h6800, 32'hD800, 16'd64);
      waitDone("t6_rerun_done", 1000);
      checkOutput("t6_ar_cnt", ar_cnt, 1);
      checkOutput("t6_aw_cnt", aw_cnt, 1);
      checkOutput("t6_b_cnt", b_cnt, 1);
      checkMem("t6_mem", 32'h6800, 32'hD800, 16);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
